relu_maxpool_13_2_12: RTL
=========================

# relu_maxpool_13_2_12

Streaming ReLU and max-pool stage that sits directly downstream of the 16-input, 4-tap, 12-bit convolution stage (conv_16_4_12_1). It consumes that stage's 13-value signed output vectors and max-pools each vector in non-overlapping windows of 2, emitting 7 values per vector. The final window of each vector is partial. With the ReLU feature compiled in, each pooled value is clamped at zero. Both sides use valid/ready handshakes, so the block drops straight into the layer pipeline.

## Interface
- L, 13: input vector length (values per vector).
- W, 2: pool window and stride.
- T, 12: data width, signed two's complement.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- x_data  input  T  signed input value.
- x_valid  input  1  x_data is valid.
- x_ready  output  1  block accepts x_data this cycle.
- y_data  output  T  signed pooled output value.
- y_valid  output  1  y_data is valid.
- y_ready  input  1  consumer accepts y_data this cycle.

## Operation
- An input transfer occurs when x_valid && x_ready.
- Counters:
  - win_cnt counts 0..W-1 within the current window.
  - vec_cnt counts 0..L-1 within the current vector.
- Running max:
  - On the first element of a window (win_cnt==0), run_max is loaded with x_data.
  - Otherwise run_max becomes the signed max of run_max and x_data.
- A window closes on the transfer where win_cnt==W-1 or vec_cnt==L-1.
  - The closing value is max(run_max, x_data) and is written to the output register.
  - win_cnt resets to 0.
  - If vec_cnt==L-1, vec_cnt also resets to 0. The partial last window therefore never spills into the next vector.
- Outputs per vector: OUTS=(L+W-1)/W, which is 7 at the defaults. 625 input vectors give 4375 outputs.
- Arithmetic: signed compare at T bits, no widening, no rounding.
- Reset mid-vector: all counters, run_max and the output register clear. The next accepted value is index 0 of a new vector.

## Timing
- Reset values:
  - y_valid=0, y_data=0.
  - win_cnt=0, vec_cnt=0, run_max=0.
  - x_ready=1.
- x_ready = !y_valid || y_ready. It is combinational and does not depend on x_valid.
- Latency: y_valid rises on the clock edge that accepts a window-closing input. Data is visible 1 cycle after that transfer.
- While y_valid && !y_ready:
  - y_data and y_valid hold stable.
  - x_ready=0, so no input is accepted.
- Same-cycle y_ready and a window-closing input: the old output retires and the new output loads on the same edge. Sustained throughput is 1 input per cycle.
- Same-cycle y_ready and a non-closing input: y_valid falls, and the input updates run_max.
- x_data is ignored when x_valid=0, including X values.

## Configuration
- RELU_MAXPOOL_RELU_EN:
  - Defined: the value written to the output register is clamped, so any negative value becomes 0.
  - Undefined: the raw signed max is emitted.
- The macro has no effect on handshake timing or counters.

## Structure
- Package relu_maxpool_pkg holds:
  - Default constants L_DEF=13, W_DEF=2, T_DEF=12.
  - Function outs_per_vec(L,W).
  - Function smax(a,b) for the signed max.
- Sub-module relu_maxpool_out_reg holds the T-bit valid/ready output register. It has ports clk, reset, d, load, y_data, y_valid, y_ready, and drives x_ready.
- The top level contains the counters, run_max, window-close logic and the ReLU clamp.

## Test plan
- Ramp vector 0..12, always valid/ready -> outputs 1,3,5,7,9,11,12, with 12 coming from the partial window.
- Vector of all -5:
  - With RELU_MAXPOOL_RELU_EN: outputs are 7×0x000.
  - Without it: outputs are 7×0xFFB.
- Mixed windows (-3,7),(-3,-8) -> 7 then 0 with RELU, 7 then 0xFFD without.
- Backpressure:
  - Hold y_ready=0 for 20 cycles after a window closes -> y_data stable, x_ready=0, no lost or duplicated values.
  - Release y_ready -> back-to-back transfers resume.
- Reset mid-vector: feed 5 values, assert reset for 1 cycle, then feed the ramp -> outputs equal the ramp case exactly, y_valid=0 immediately on reset.
- Random x_valid/y_ready over 625 vectors of random 12-bit data -> 4375 outputs match the reference model with 0 errors.

Source files
------------

// File: rtl/relu_maxpool_pkg.sv
// Shared constants and helpers for the streaming ReLU / max-pool stage.
// Optional clamp is selected with RELU_MAXPOOL_RELU_EN in relu_maxpool_13_2_12.
package relu_maxpool_pkg;

  localparam int unsigned L_DEF = 13;
  localparam int unsigned W_DEF = 2;
  localparam int unsigned T_DEF = 12;

  // Number of pooled values per vector, counting the partial last window.
  function automatic int unsigned outs_per_vec(input int unsigned l, input int unsigned w);
    return (l + w - 1) / w;
  endfunction

  function automatic logic signed [T_DEF-1:0] smax(input logic signed [T_DEF-1:0] a,
                                                   input logic signed [T_DEF-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_maxpool_out_reg.sv
// Single-entry valid/ready output register; x_ready lets a new value in whenever
// the slot is empty or is being drained on the same edge.
module relu_maxpool_out_reg
  import relu_maxpool_pkg::*;
#(
  parameter int unsigned T = T_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] d,
  input  logic                load,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready,
  output logic                x_ready
);

  assign x_ready = !y_valid || y_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_valid <= 1'b0;
      y_data  <= '0;
    end else if (load) begin
      y_valid <= 1'b1;
      y_data  <= d;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/relu_maxpool_13_2_12.sv
// Streaming max-pool (window/stride W) over L-value signed vectors, with an optional
// zero clamp on each pooled value when RELU_MAXPOOL_RELU_EN is defined.
module relu_maxpool_13_2_12
  import relu_maxpool_pkg::*;
#(
  parameter int unsigned L = L_DEF,
  parameter int unsigned W = W_DEF,
  parameter int unsigned T = T_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int unsigned WinW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned VecW = (L > 1) ? $clog2(L) : 1;

  logic [WinW-1:0]     win_cnt_q, win_cnt_d;
  logic [VecW-1:0]     vec_cnt_q, vec_cnt_d;
  logic signed [T-1:0] run_max_q, run_max_d;
  logic signed [T-1:0] cand;
  logic signed [T-1:0] out_val;
  logic                xfer;
  logic                win_first;
  logic                win_last;
  logic                vec_last;
  logic                close;

  assign xfer      = x_valid && x_ready;
  assign win_first = (win_cnt_q == '0);
  assign win_last  = (win_cnt_q == WinW'(W - 1));
  assign vec_last  = (vec_cnt_q == VecW'(L - 1));
  assign close     = xfer && (win_last || vec_last);

  // A one-element window (partial tail) must not see the previous window's run_max.
  assign cand = win_first ? x_data : smax(run_max_q, x_data);

`ifdef RELU_MAXPOOL_RELU_EN
  assign out_val = cand[T-1] ? '0 : cand;
`else
  assign out_val = cand;
`endif

  always_comb begin
    win_cnt_d = win_cnt_q;
    vec_cnt_d = vec_cnt_q;
    run_max_d = run_max_q;
    if (xfer) begin
      run_max_d = cand;
      if (win_last || vec_last) begin
        win_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
      end
      if (vec_last) begin
        vec_cnt_d = '0;
      end else begin
        vec_cnt_d = vec_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q <= '0;
      vec_cnt_q <= '0;
      run_max_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      run_max_q <= run_max_d;
    end
  end

  relu_maxpool_out_reg #(
    .T (T)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .d       (out_val),
    .load    (close),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .x_ready (x_ready)
  );

endmodule
